cpu_opponent: RTL and testbench
===============================

// Module: cpu_opponent
// PURPOSE
//  Computer player for tug-of-war vs CPU: produces the right-player press pulses that feed the
//  playfield lights and the win-condition FSM (its R input), i.e. the stimulus side of the press interface.
//  Pseudo-random LFSR value compared against a switch-set difficulty on each prescaled tick; freezes on game over.
//  Output press is a clean 1-cycle pulse, same shape as an edge-detected human key.
// PARAMETERS
//  LFSR_W      10  LFSR width (taps fixed for 10: x^10+x^7+1)
//  DIFF_W       9  difficulty width; compared zero-extended against LFSR
//  TICK_DIV     4  decision period in clk cycles (>=1; 1 = every cycle)
//  GAP_CYCLES   1  minimum low cycles after each press (>=1)
// PORTS
//  clk         in   1       system clock
//  reset       in   1       synchronous, active-high
//  enable      in   1       1 = CPU allowed to play
//  game_over   in   1       1 = winner decided (win FSM out of off state); blocks presses
//  difficulty  in   DIFF_W  press threshold; higher = presses more often
//  cpu_press   out  1       1-cycle press pulse (drives R of win/playfield logic)
//  lfsr_state  out  LFSR_W  current LFSR value (debug/verification)
// BEHAVIOUR
//  Reset: lfsr=0, prescaler=0, state=ARMED, cpu_press=0; all take effect on the edge reset is sampled high.
//  LFSR: XNOR Fibonacci, lfsr <= {lfsr[8:0], ~(lfsr[9]^lfsr[6])}; advances every non-reset cycle,
//   regardless of enable/game_over. Seed 0 legal; all-ones is lockup, unreachable from 0. Period 1023.
//   Sequence from 0: 001,003,007,00F,01F,03F,07F,0FE,1FC,3F8,3F1...
//  Prescaler: counts 0..TICK_DIV-1 and wraps; tick = (count==TICK_DIV-1) & enable & ~game_over.
//   Held at 0 while enable=0 or game_over=1; resumes from 0.
//  Decision: on tick while in ARMED, press iff lfsr < {0,difficulty} (unsigned, value in tick cycle,
//   difficulty sampled live). difficulty=0 never presses; max 0x1FF -> ~50% of ticks.
//  FSM (registered output cpu_press = (state==PRESS)):
//   ARMED: tick & hit -> PRESS; else ARMED.
//   PRESS: exactly 1 cycle -> GAP (gap counter loaded to GAP_CYCLES-1).
//   GAP  : stay until gap counter==0 -> ARMED. Ticks arriving in PRESS/GAP are dropped, not queued.
//  Latency: tick cycle N with hit -> cpu_press high in cycle N+1 only.
//  game_over rising while in PRESS: current pulse completes (1 cycle), no further presses.
//   game_over while in GAP: gap still completes; then stays ARMED with no ticks.
//  enable falling: same as game_over (no new decisions; in-flight pulse not truncated).
//  Reset mid-pulse: cpu_press low the cycle after reset sampled; never 2-cycle pulse.
//  Never two presses closer than GAP_CYCLES+1 cycles.
// STRUCTURE
//  Package tow_pkg: typedef enum logic [1:0] {ARMED, PRESS, GAP} cpu_state_t; LFSR tap constants;
//   shared HEX patterns (HEX_OFF=7'b1111111, HEX_1, HEX_2) used with win display.
//  Sub-module lfsr10 (clk, reset, q[9:0]) free-running XNOR LFSR; prescaler, gap counter, FSM inline.
// TESTING
//  Reset 2 cycles, enable=1, difficulty=0x1FF, game_over=0: cycle index k from first low-reset cycle;
//   lfsr_state=0x007 at k=3 (tick) -> cpu_press=1 at k=4 only; low k=5..7.
//  Continue: tick k=7 lfsr=0x07F -> press at k=8; tick k=11 lfsr=0x3F1 >= 0x1FF -> no press at k=12.
//  difficulty=0, enable=1 for 2000 cycles -> cpu_press never asserts; lfsr never 0x3FF.
//  Same as first scenario but game_over=1 at k=4 -> press at k=4 still 1 cycle; no press for 50 cycles;
//   drop game_over -> prescaler restarts at 0, first tick 4 cycles later.
//  reset asserted in PRESS cycle -> cpu_press=0 next cycle, lfsr_state=0x000, state ARMED.
//  Random difficulty/enable over 10k cycles -> assert every cpu_press pulse width 1, spacing >= GAP_CYCLES+1,
//   press only after a tick with lfsr < difficulty (scoreboard model).

Source files
------------

// File: rtl/tow_pkg.sv
// Shared types and constants for the tug-of-war game blocks.
// Holds the CPU opponent state encoding, the LFSR tap positions and the
// seven-segment patterns used by the win display (active-low segments, gfedcba).
package tow_pkg;

  typedef enum logic [1:0] {
    ARMED = 2'd0,
    PRESS = 2'd1,
    GAP   = 2'd2
  } cpu_state_t;

  // 10-bit XNOR Fibonacci LFSR, polynomial x^10 + x^7 + 1.
  localparam int LFSR_W_C   = 10;
  localparam int LFSR_TAP_A = 9;
  localparam int LFSR_TAP_B = 6;

  localparam logic [6:0] HEX_OFF = 7'b1111111;
  localparam logic [6:0] HEX_1   = 7'b1111001;
  localparam logic [6:0] HEX_2   = 7'b0100100;

endpackage

// File: rtl/lfsr10.sv
// Free-running 10-bit XNOR LFSR; advances every cycle that reset is low.
// Seed 0 is legal (XNOR form); all-ones is the lockup state and is unreachable from 0.
// Period 1023; no enable, it never stalls.
module lfsr10
  import tow_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  output logic [LFSR_W_C-1:0] q
);

  logic [LFSR_W_C-1:0] lfsr_q;
  logic [LFSR_W_C-1:0] lfsr_d;

  // Shift left, feed back the XNOR of the two taps into bit 0.
  always_comb begin
    lfsr_d = {lfsr_q[LFSR_W_C-2:0], ~(lfsr_q[LFSR_TAP_A] ^ lfsr_q[LFSR_TAP_B])};
  end

  // State register with synchronous reset to the zero seed.
  always_ff @(posedge clk) begin
    if (reset) lfsr_q <= '0;
    else       lfsr_q <= lfsr_d;
  end

  assign q = lfsr_q;

endmodule

// File: rtl/cpu_opponent.sv
// CPU player: on each prescaled tick, presses if the LFSR is below the difficulty threshold.
// Latency: tick in cycle N with a hit gives a 1-cycle cpu_press in cycle N+1.
// enable low / game_over high stop new decisions; a pulse already issued always completes.
module cpu_opponent
  import tow_pkg::*;
#(
  parameter int LFSR_W     = LFSR_W_C,  // taps are fixed for 10 bits
  parameter int DIFF_W     = 9,
  parameter int TICK_DIV   = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              game_over,
  input  logic [DIFF_W-1:0] difficulty,
  output logic              cpu_press,
  output logic [LFSR_W-1:0] lfsr_state
);

  localparam int PS_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(TICK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);

  logic [LFSR_W-1:0] lfsr_val;
  logic [LFSR_W-1:0] diff_ext;
  logic              run;
  logic              tick;
  logic              hit;

  logic [PS_W-1:0]   ps_q,    ps_d;
  logic [GAP_W-1:0]  gap_q,   gap_d;
  cpu_state_t        state_q, state_d;

  lfsr10 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .q     (lfsr_val)
  );

  assign lfsr_state = lfsr_val;
  assign diff_ext   = LFSR_W'(difficulty);
  assign run        = enable & ~game_over;
  assign tick       = run & (ps_q == PS_LAST);
  assign hit        = (lfsr_val < diff_ext);

  // Prescaler: wraps at TICK_DIV-1, parked at 0 whenever play is blocked so it restarts cleanly.
  always_comb begin
    ps_d = ps_q + PS_W'(1);
    if (!run || ps_q == PS_LAST) ps_d = '0;
  end

  // Press FSM: a tick hit in ARMED fires one PRESS cycle, then GAP holds off further decisions.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    unique case (state_q)
      ARMED: begin
        if (tick && hit) state_d = PRESS;
      end
      PRESS: begin
        state_d = GAP;
        gap_d   = GAP_LOAD;
      end
      GAP: begin
        if (gap_q == '0) state_d = ARMED;
        else             gap_d   = gap_q - GAP_W'(1);
      end
      default: state_d = ARMED;
    endcase
  end

  // Registers; reset drops any in-flight pulse on the following cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      ps_q    <= '0;
      gap_q   <= '0;
      state_q <= ARMED;
    end else begin
      ps_q    <= ps_d;
      gap_q   <= gap_d;
      state_q <= state_d;
    end
  end

  assign cpu_press = (state_q == PRESS);

endmodule

// File: tb/tb_cpu_opponent.sv
// Testbench for cpu_opponent: directed vectors for the documented timing cases,
// then a randomized run compared cycle by cycle against a behavioural model.
module tb_cpu_opponent;

  localparam int TICK_DIV   = 4;
  localparam int GAP_CYCLES = 1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       game_over = 1'b0;
  logic [8:0] difficulty = '0;
  logic       cpu_press;
  logic [9:0] lfsr_state;

  int n_checks = 0;
  int n_errors = 0;

  cpu_opponent #(
    .LFSR_W     (10),
    .DIFF_W     (9),
    .TICK_DIV   (TICK_DIV),
    .GAP_CYCLES (GAP_CYCLES)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .game_over  (game_over),
    .difficulty (difficulty),
    .cpu_press  (cpu_press),
    .lfsr_state (lfsr_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [9:0] lfsr_next(input logic [9:0] v);
    return {v[8:0], ~(v[9] ^ v[6])};
  endfunction

  function automatic logic [9:0] lfsr_at(input int n);
    logic [9:0] v = '0;
    for (int i = 0; i < n; i++) v = lfsr_next(v);
    return v;
  endfunction

  // One clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Two reset cycles; on return the bench sits in cycle k=0.
  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  // Behavioural reference model, used by the randomized phase.
  int         m_state;  // 0 armed, 1 press, 2 gap
  int         m_gap;
  int         m_cnt;
  logic [9:0] m_lfsr;
  logic       m_tickhit;
  logic       m_t, m_h;

  always @(posedge clk) begin
    if (reset) begin
      m_state   <= 0;
      m_gap     <= 0;
      m_cnt     <= 0;
      m_lfsr    <= '0;
      m_tickhit <= 1'b0;
    end else begin
      m_t = (m_cnt == TICK_DIV - 1) && enable && !game_over;
      m_h = ({1'b0, difficulty} > m_lfsr);
      m_lfsr    <= lfsr_next(m_lfsr);
      m_cnt     <= (!enable || game_over || m_cnt == TICK_DIV - 1) ? 0 : m_cnt + 1;
      m_tickhit <= m_t && m_h;
      case (m_state)
        0: if (m_t && m_h) m_state <= 1;
        1: begin m_state <= 2; m_gap <= GAP_CYCLES - 1; end
        default: if (m_gap == 0) m_state <= 0; else m_gap <= m_gap - 1;
      endcase
    end
  end

  initial begin
    int k;
    int n_press;
    int n_lock;
    int last_press;
    logic prev_press;

    // ---- Scenario 1: basic decisions at max difficulty ----
    enable = 1'b1;
    difficulty = 9'h1FF;
    game_over = 1'b0;
    do_reset();
    check("rst_press", cpu_press, 0);
    check("rst_lfsr", lfsr_state, 10'h000);
    for (k = 1; k <= 12; k++) begin
      step();
      case (k)
        1: check("k1_lfsr", lfsr_state, 10'h001);
        3: begin check("k3_lfsr", lfsr_state, 10'h007); check("k3_press", cpu_press, 0); end
        4: check("k4_press", cpu_press, 1);
        5, 6: check("gap_low", cpu_press, 0);
        7: begin check("k7_lfsr", lfsr_state, 10'h07F); check("k7_press", cpu_press, 0); end
        8: check("k8_press", cpu_press, 1);
        9, 10: check("k9_10_low", cpu_press, 0);
        11: check("k11_lfsr", lfsr_state, 10'h3F1);
        12: check("k12_nopress", cpu_press, 0);
        default: ;
      endcase
    end

    // ---- Scenario 2: difficulty 0 never presses ----
    difficulty = 9'h000;
    do_reset();
    n_press = 0;
    n_lock = 0;
    for (int i = 0; i < 2000; i++) begin
      step();
      if (cpu_press) n_press++;
      if (lfsr_state == 10'h3FF) n_lock++;
    end
    check("diff0_presses", n_press, 0);
    check("diff0_lockup", n_lock, 0);

    // ---- Scenario 3: game_over during a press ----
    difficulty = 9'h1FF;
    do_reset();
    for (k = 1; k <= 4; k++) step();
    check("go_k4_press", cpu_press, 1);
    game_over = 1'b1;
    step(); k = 5;
    check("go_k5_low", cpu_press, 0);
    n_press = 0;
    for (int i = 0; i < 50; i++) begin
      step(); k++;
      if (cpu_press) n_press++;
    end
    check("go_hold_presses", n_press, 0);
    // Release at a cycle where the first tick (3 cycles later) is a guaranteed hit.
    for (int i = 0; i < 200 && lfsr_at(k + 3) >= 10'h1FF; i++) begin
      step(); k++;
    end
    check("go_release_lfsr", lfsr_state, lfsr_at(k));
    game_over = 1'b0;
    n_press = 0;
    for (int i = 1; i <= 3; i++) begin
      step(); k++;
      if (cpu_press) n_press++;
    end
    check("go_restart_early", n_press, 0);
    step(); k++;
    check("go_restart_tick", cpu_press, 1);

    // ---- Scenario 4: reset asserted in the press cycle ----
    do_reset();
    for (k = 1; k <= 4; k++) step();
    check("rp_press", cpu_press, 1);
    reset = 1'b1;
    step();
    check("rp_press_cleared", cpu_press, 0);
    check("rp_lfsr_cleared", lfsr_state, 10'h000);
    reset = 1'b0;
    n_press = 0;
    for (k = 1; k <= 3; k++) begin
      step();
      if (cpu_press) n_press++;
    end
    check("rp_quiet", n_press, 0);
    step();
    check("rp_armed_again", cpu_press, 1);

    // ---- Scenario 5: randomized run against the model ----
    do_reset();
    enable = 1'b1;
    game_over = 1'b0;
    difficulty = 9'($urandom_range(0, 511));
    prev_press = 1'b0;
    last_press = -100;
    n_press = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      if ($urandom_range(0, 63) == 0) difficulty = 9'($urandom_range(0, 511));
      if ($urandom_range(0, 99) == 0) enable = ~enable;
      if (!game_over && $urandom_range(0, 199) == 0) game_over = 1'b1;
      else if (game_over && $urandom_range(0, 49) == 0) game_over = 1'b0;
      step();
      check("rnd_lfsr", lfsr_state, m_lfsr);
      check("rnd_press", cpu_press, (m_state == 1) ? 1 : 0);
      if (cpu_press) begin
        n_press++;
        check("rnd_width", prev_press, 0);
        check("rnd_spacing", (cyc - last_press) >= GAP_CYCLES + 1, 1);
        check("rnd_after_tick_hit", m_tickhit, 1);
        last_press = cyc;
      end
      prev_press = cpu_press;
    end
    check("rnd_some_presses", n_press > 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
